fmul_pipe_ctrl: RTL and testbench

FMUL_PIPE_CTRL -- requirements
Module: fmul_pipe_ctrl

---
 rtl/fmul_pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_fmul_pipe_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe_ctrl.sv
// fmul_pipe_ctrl: front-end arbiter and pipeline control for a 3-stage
// single-precision multiplier. Two requesters share the multiplier through a
// round-robin grant. The datapath stages live outside this block and are
// clocked by en_ma/en_an. This block tracks per-stage valid bits and the
// src/tag sideband, and owns the registered result.
module fmul_pipe_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             en_ma,
  output logic             en_an,
  input  logic             flush,
  input  logic [31:0]      norm_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic             r_v1, r_v2, r_v3;
  logic             r_src1, r_src2, r_src3;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  logic [31:0]      r_q;
  // Index of the requester granted most recently; reset to 1 so that
  // requester 0 wins the first contested cycle.
  logic             r_last;

  logic w_stall;
  logic w_gnt0, w_gnt1;
  logic w_accept;
  logic w_sel;

  // The whole pipeline freezes only when a result is waiting and nobody takes it.
  assign w_stall = r_v3 & ~out_ready;

  // Round-robin grant. It is suppressed while stalled or flushing.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!w_stall && !flush) begin
      if (req0_valid && req1_valid) begin
        if (r_last) w_gnt0 = 1'b1;
        else        w_gnt1 = 1'b1;
      end else if (req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_accept   = w_gnt0 | w_gnt1;
  // With no grant, the mux keeps pointing at the last winner so operands are never X.
  assign w_sel      = w_gnt1 | (~w_gnt0 & r_last);
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign mul_a      = w_sel ? req1_a : req0_a;
  assign mul_b      = w_sel ? req1_b : req0_b;
  assign en_ma      = ~w_stall;
  assign en_an      = ~w_stall;

  // The priority pointer moves only on a real accept.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)         r_last <= 1'b1;
    else if (w_accept) r_last <= w_gnt1;
  end

  // Stage valid bits: flush beats stall; otherwise shift together when not stalled.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (!w_stall) begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Sideband and result shift in lockstep with the valid bits; the result loads only from a valid stage.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_src1 <= 1'b0;
      r_src2 <= 1'b0;
      r_src3 <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_q    <= '0;
    end else if (!flush && !w_stall) begin
      r_src1 <= w_gnt1;
      r_tag1 <= w_gnt1 ? req1_tag : req0_tag;
      r_src2 <= r_src1;
      r_tag2 <= r_tag1;
      r_src3 <= r_src2;
      r_tag3 <= r_tag2;
      if (r_v2) r_q <= norm_q;
    end
  end

  assign out_valid = r_v3;
  assign out_q     = r_q;
  assign out_src   = r_src3;
  assign out_tag   = r_tag3;
  assign busy      = r_v1 | r_v2 | r_v3;

endmodule

// File: tb/tb_fmul_pipe_ctrl.sv
// Bench for fmul_pipe_ctrl: an external 2-stage datapath stub, a queue-based
// reference model checked every cycle, and directed cases with literal expectations.
module tb_fmul_pipe_ctrl;
  localparam int TAG_W = 4;

  logic clk, clrn;
  logic req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic req0_ready, req1_ready;
  logic [31:0] mul_a, mul_b;
  logic en_ma, en_an, flush;
  logic [31:0] norm_q;
  logic out_valid, out_ready;
  logic [31:0] out_q;
  logic out_src;
  logic [TAG_W-1:0] out_tag;
  logic busy;

  int checks = 0;
  int failures = 0;

  fmul_pipe_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .en_ma(en_ma), .en_an(en_an),
    .flush(flush), .norm_q(norm_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_src(out_src), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating fp32 multiply for normal operands; NaN in gives quiet NaN, zero/denormal gives zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 32'h7FC00000;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  // Datapath stub: multiply-add register then add-normalize register.
  logic [31:0] dp_ma, dp_an;
  always @(posedge clk) begin
    if (en_ma) dp_ma <= fmul(mul_a, mul_b);
    if (en_an) dp_an <= dp_ma;
  end
  assign norm_q = dp_an;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted op waits a number of unstalled edges before it is visible.
  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      q;
    logic [1:0]       rem;
  } ent_t;
  ent_t mq[$];
  logic m_last;
  logic m_any;

  function automatic logic head_vis();
    return (mq.size() > 0) && (mq[0].rem == 2'd0);
  endfunction

  function automatic logic [1:0] rr_grant(input logic st);
    if (st || flush) return 2'b00;
    if (req0_valid && req1_valid) return m_last ? 2'b01 : 2'b10;
    if (req0_valid) return 2'b01;
    if (req1_valid) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge clrn) begin
    logic [1:0] g;
    logic st;
    if (!clrn) begin
      mq.delete();
      m_last = 1'b1;
      m_any  = 1'b0;
    end else begin
      st = head_vis() && !out_ready;
      g  = rr_grant(st);
      if (flush) mq.delete();
      else if (!st) begin
        if (head_vis()) void'(mq.pop_front());
        for (int i = 0; i < mq.size(); i++) mq[i].rem = mq[i].rem - 2'd1;
        if (g[0]) mq.push_back('{src: 1'b0, tag: req0_tag, q: fmul(req0_a, req0_b), rem: 2'd2});
        if (g[1]) mq.push_back('{src: 1'b1, tag: req1_tag, q: fmul(req1_a, req1_b), rem: 2'd2});
        if (g != 2'b00) begin
          m_last = g[1];
          m_any  = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [1:0] g;
    logic st, hv;
    if (clrn) begin
      hv = head_vis();
      st = hv && !out_ready;
      g  = rr_grant(st);
      check("m_req0_ready", {31'd0, req0_ready}, {31'd0, g[0]});
      check("m_req1_ready", {31'd0, req1_ready}, {31'd0, g[1]});
      check("m_en_ma", {31'd0, en_ma}, {31'd0, !st});
      check("m_en_an", {31'd0, en_an}, {31'd0, !st});
      check("m_busy", {31'd0, busy}, {31'd0, mq.size() > 0});
      check("m_out_valid", {31'd0, out_valid}, {31'd0, hv});
      if (hv) begin
        check("m_out_q", out_q, mq[0].q);
        check("m_out_src", {31'd0, out_src}, {31'd0, mq[0].src});
        check("m_out_tag", {28'd0, out_tag}, {28'd0, mq[0].tag});
      end
      if (g != 2'b00) begin
        check("m_mul_a", mul_a, g[1] ? req1_a : req0_a);
        check("m_mul_b", mul_b, g[1] ? req1_b : req0_b);
      end else if (m_any) begin
        check("m_mul_a_hold", mul_a, m_last ? req1_a : req0_a);
      end
    end
  end

  function automatic logic [31:0] rnd_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  logic [31:0] held_q;
  logic [TAG_W-1:0] exp_tags [4];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0;
    req0_valid = 0; req1_valid = 0; flush = 0; out_ready = 1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_tag = 0; req1_tag = 0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_q", out_q, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    do_reset();

    // Single op from requester 0, accepted on the first edge after reset release.
    req0_valid = 1; req0_a = 32'h3FC00000; req0_b = 32'h40000000; req0_tag = 4'd5;
    @(negedge clk) check("t1_ready0", {31'd0, req0_ready}, 32'd1);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk) check("t1_not_yet", {31'd0, out_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_q", out_q, 32'h40400000);
    check("t1_out_src", {31'd0, out_src}, 32'd0);
    check("t1_out_tag", {28'd0, out_tag}, 32'd5);
    next_cycle();

    // Both requesters valid for 4 cycles: grants alternate 0,1,0,1 and results stay ordered.
    do_reset();
    exp_tags[0] = 4'd0; exp_tags[1] = 4'd9; exp_tags[2] = 4'd2; exp_tags[3] = 4'd11;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        req0_valid = 1; req1_valid = 1;
        req0_a = rnd_op(); req0_b = rnd_op(); req1_a = rnd_op(); req1_b = rnd_op();
        req0_tag = 4'(c); req1_tag = 4'(8 + c);
      end else idle();
      @(negedge clk);
      if (c < 4) begin
        check("t2_ready0", {31'd0, req0_ready}, {31'd0, c % 2 == 0});
        check("t2_ready1", {31'd0, req1_ready}, {31'd0, c % 2 == 1});
      end
      if (c >= 3 && c < 7) begin
        check("t2_out_valid", {31'd0, out_valid}, 32'd1);
        check("t2_out_tag", {28'd0, out_tag}, {28'd0, exp_tags[c-3]});
        check("t2_out_src", {31'd0, out_src}, {31'd0, (c - 3) % 2 == 1});
      end
      next_cycle();
    end

    // Full pipeline held for 5 cycles, then drained back-to-back.
    out_ready = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) begin
        req0_valid = 1; req1_valid = 0; req0_a = rnd_op(); req0_b = rnd_op(); req0_tag = 4'(c + 1);
      end else if (c < 8) begin
        req0_valid = 1; req1_valid = 1; req0_tag = 4'd4; req1_tag = 4'd4;
      end else begin
        idle(); out_ready = 1;
      end
      @(negedge clk);
      if (c == 3) held_q = out_q;
      if (c >= 3 && c < 8) begin
        check("t3_hold_tag", {28'd0, out_tag}, 32'd1);
        check("t3_hold_q", out_q, held_q);
        check("t3_ready0_low", {31'd0, req0_ready}, 32'd0);
        check("t3_ready1_low", {31'd0, req1_ready}, 32'd0);
        check("t3_en_ma_low", {31'd0, en_ma}, 32'd0);
        check("t3_en_an_low", {31'd0, en_an}, 32'd0);
      end
      if (c >= 8 && c < 11) begin
        check("t3_drain_valid", {31'd0, out_valid}, 32'd1);
        check("t3_drain_tag", {28'd0, out_tag}, 32'(c - 7));
      end
      if (c == 11) check("t3_drained", {31'd0, out_valid}, 32'd0);
      next_cycle();
    end

    // Flush with all three stages full, while out_ready is low.
    out_ready = 1;
    for (int c = 0; c < 9; c++) begin
      if (c < 3) begin
        req0_valid = 1; req0_a = rnd_op(); req0_b = rnd_op(); req0_tag = 4'(c + 12);
      end else if (c == 3) begin
        flush = 1; out_ready = 0; req0_valid = 1; req1_valid = 1;
      end else begin
        idle(); out_ready = 1;
      end
      @(negedge clk);
      if (c == 3) begin
        check("t4_busy_before", {31'd0, busy}, 32'd1);
        check("t4_ready0_flush", {31'd0, req0_ready}, 32'd0);
        check("t4_ready1_flush", {31'd0, req1_ready}, 32'd0);
      end
      if (c >= 4) begin
        check("t4_out_valid", {31'd0, out_valid}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
      end
      next_cycle();
    end

    // Asynchronous reset while an op sits in the second stage.
    req0_valid = 1; req0_a = rnd_op(); req0_b = rnd_op(); req0_tag = 4'd7;
    next_cycle(); idle();
    next_cycle();
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    #1 clrn = 1'b0;
    #1;
    check("t5_async_valid", {31'd0, out_valid}, 32'd0);
    check("t5_async_busy", {31'd0, busy}, 32'd0);
    check("t5_async_q", out_q, 32'd0);
    check("t5_async_tag", {28'd0, out_tag}, 32'd0);
    check("t5_async_src", {31'd0, out_src}, 32'd0);
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk) check("t5_no_stale", {31'd0, out_valid}, 32'd0);
      next_cycle();
    end

    // NaN operand from requester 1.
    req1_valid = 1; req1_a = 32'h7FC00001; req1_b = 32'h3F800000; req1_tag = 4'hA;
    next_cycle(); idle();
    next_cycle(); next_cycle();
    @(negedge clk);
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    check("t6_exp", {24'd0, out_q[30:23]}, 32'h000000FF);
    check("t6_frac_nz", {31'd0, out_q[22:0] != 23'd0}, 32'd1);
    check("t6_tag", {28'd0, out_tag}, 32'hA);
    check("t6_src", {31'd0, out_src}, 32'd1);
    next_cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a = rnd_op(); req0_b = rnd_op(); req1_a = rnd_op(); req1_b = rnd_op();
      req0_tag = 4'($urandom); req1_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      next_cycle();
    end
    idle(); out_ready = 1;
    repeat (6) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
